capsense_scan: RTL and testbench
================================

CAPSENSE_SCAN -- requirements
Module: capsense_scan

Interface
REQ-001 SHALL have parameter NUM_SENSE, default 4: number of sensor channels, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 16: width of each rise-time count and threshold.
REQ-003 SHALL have parameter DISCH_CYC, default 100: number of cycles the discharge phase lasts, minimum 1.
REQ-004 SHALL have parameter HYST, default 8: hysteresis in counts applied when releasing a touch.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: allows new scans to start.
REQ-008 SHALL have port sense_in, input, NUM_SENSE bits: raw asynchronous sensor pins.
REQ-009 SHALL have port charge_out, output, 1 bit: shared charge drive to all sensors.
REQ-010 SHALL have port thr_we, input, 1 bit: threshold write strobe.
REQ-011 SHALL have port thr_sel, input, 4 bits: threshold channel index.
REQ-012 SHALL have port thr_data, input, CNT_W bits: threshold write data.
REQ-013 SHALL have port count_out, output, NUM_SENSE*CNT_W bits: last count per channel, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port touched, output, NUM_SENSE bits: debounced touch state per channel.
REQ-015 SHALL have port timeout, output, NUM_SENSE bits: channel did not rise in the last scan.
REQ-016 SHALL have port scan_done, output, 1 bit: one-cycle pulse when results update.

Function
REQ-017 Each sense_in bit SHALL pass through a 2-flop synchronizer; all measurement SHALL use the synchronized value (sync).
REQ-018 The FSM SHALL have states IDLE, CHARGE, DISCHARGE and UPDATE; reset SHALL force IDLE.
REQ-019 In IDLE, charge_out SHALL be 0, and enable=1 SHALL move the FSM to CHARGE on the next cycle.
REQ-020 In CHARGE, charge_out SHALL be 1 and an unsigned counter SHALL be 0 in the first CHARGE cycle and increment by 1 each cycle thereafter.
REQ-021 Channel i SHALL latch the counter value in the first CHARGE cycle in which sync[i]=1, and SHALL NOT relatch later in the same scan.
REQ-022 CHARGE SHALL exit to DISCHARGE after the cycle in which all channels have latched, or after the cycle in which the counter equals 2^CNT_W-1, whichever occurs first.
REQ-023 A channel not latched when CHARGE exits SHALL take count 2^CNT_W-1 and SHALL be flagged as timed out for this scan.
REQ-024 DISCHARGE SHALL drive charge_out=0 for exactly DISCH_CYC cycles, then go to UPDATE.
REQ-025 UPDATE SHALL last one cycle, after which the FSM SHALL go to CHARGE if enable=1, else to IDLE.
REQ-026 Results SHALL be registered on the UPDATE cycle, so that on the following cycle count_out and timeout hold the new values and scan_done=1 for exactly that one cycle.
REQ-027 For a non-timed-out channel, touched[i] SHALL set when count > thr[i], clear when count < thr[i]-HYST (subtraction saturating at 0), and otherwise hold.
REQ-028 For a timed-out channel, touched[i] SHALL hold its previous value.
REQ-029 Deasserting enable mid-scan SHALL NOT abort the scan; the scan SHALL complete and the FSM SHALL then return to IDLE.
REQ-030 A thr_we pulse SHALL store thr_data into thr[thr_sel] on the next edge.
REQ-031 A threshold write with thr_sel >= NUM_SENSE SHALL be ignored.
REQ-032 A threshold write coinciding with UPDATE SHALL store the new value, while that UPDATE SHALL compare against the old value.
REQ-033 sense_in changes during DISCHARGE, UPDATE or IDLE SHALL have no effect on any output.

Reset
REQ-034 Reset SHALL act from any state (including mid-scan) within one cycle: state IDLE, charge_out=0, count_out=0, touched=0, timeout=0, scan_done=0, synchronizers=0, and all thr[i]=2^CNT_W-1.
REQ-035 If enable=1 when reset deasserts, CHARGE SHALL begin one cycle after the first IDLE cycle.

Verification
(All scenarios use NUM_SENSE=4, CNT_W=8, DISCH_CYC=4, HYST=2.)
REQ-036 Reset held with enable=0 for 10 cycles, then released -> every output is 0, charge_out stays 0, and there is no scan_done pulse.
REQ-037 enable=1, sense_in raw bits 0..3 rise at cycles 10/20/30/40 after the first CHARGE cycle -> count_out = 12/22/32/42, timeout=0, charge_out high for 43 cycles then low for 4 cycles, scan_done pulse 1 cycle after UPDATE.
REQ-038 thr[2]=30, consecutive scans give ch2 counts 35, 29, 27 -> touched[2] goes 1, then holds 1, then clears to 0.
REQ-039 Channel 3 held low while others rise early -> CHARGE lasts 256 cycles, count_out[3]=255, timeout[3]=1, touched[3] unchanged.
REQ-040 Reset pulsed mid-CHARGE with enable=1 -> next cycle charge_out=0 and outputs are 0; a fresh scan then starts with the counter at 0.
REQ-041 thr_we with thr_sel=5 -> no threshold changes; thr_we with thr_sel=1 in the UPDATE cycle -> the old threshold is used now and the new one on the next scan.

Source files
------------

// File: rtl/capsense_scan.sv
// capsense_scan: capacitive touch scanner using rise-time measurement.
//   Each scan drives a shared charge line high. A free-running counter
//   starts at zero, and each channel latches the counter value when its
//   synchronized pin first reads high. After a fixed discharge interval,
//   the results, timeout flags and hysteresis-filtered touch states are
//   updated, and scan_done pulses once.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset
//   i_enable     allows new scans to start
//   i_sense_in   raw asynchronous sensor pins [NUM_SENSE]
//   o_charge_out shared charge drive
//   i_thr_we     threshold write strobe
//   i_thr_sel    threshold channel index
//   i_thr_data   threshold write data
//   o_count_out  last count per channel, channel i at [i*CNT_W +: CNT_W]
//   o_touched    debounced touch state per channel
//   o_timeout    channel did not rise in the last scan
//   o_scan_done  one-cycle pulse when the results update

// Threshold register file: one threshold per channel. Writes to an
// out-of-range index are dropped.
module capsense_thr_regs #(
  parameter int NUM_SENSE = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_we,
  input  logic [3:0]                 i_sel,
  input  logic [CNT_W-1:0]           i_data,
  output logic [NUM_SENSE*CNT_W-1:0] o_thr
);
  logic [NUM_SENSE*CNT_W-1:0] r_thr;
  logic                       w_sel_ok;

  assign w_sel_ok = ({1'b0, i_sel} < 5'(NUM_SENSE));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_thr <= '1;
    end else if (i_we && w_sel_ok) begin
      r_thr[i_sel*CNT_W +: CNT_W] <= i_data;
    end
  end

  assign o_thr = r_thr;
endmodule

// state     | meaning
// S_IDLE    | charge off, waiting for enable
// S_CHARGE  | charge on, counting and latching rise times
// S_DISCHARGE | charge off for DISCH_CYC cycles
// S_UPDATE  | one cycle: results and touch states are registered
module capsense_scan #(
  parameter int NUM_SENSE = 4,
  parameter int CNT_W     = 16,
  parameter int DISCH_CYC = 100,
  parameter int HYST      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [NUM_SENSE-1:0]       i_sense_in,
  output logic                       o_charge_out,
  input  logic                       i_thr_we,
  input  logic [3:0]                 i_thr_sel,
  input  logic [CNT_W-1:0]           i_thr_data,
  output logic [NUM_SENSE*CNT_W-1:0] o_count_out,
  output logic [NUM_SENSE-1:0]       o_touched,
  output logic [NUM_SENSE-1:0]       o_timeout,
  output logic                       o_scan_done
);
  localparam int               DW      = $clog2(DISCH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HYST_V  = CNT_W'(HYST);

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_DISCHARGE, S_UPDATE} state_t;

  state_t                     r_state, w_next;
  logic [NUM_SENSE-1:0]       r_sync1, r_sync2;
  logic [CNT_W-1:0]           r_cnt;
  logic [DW-1:0]              r_dis;
  logic [NUM_SENSE-1:0]       r_latched;
  logic [CNT_W-1:0]           r_lat [NUM_SENSE];
  logic [NUM_SENSE*CNT_W-1:0] r_count;
  logic [NUM_SENSE-1:0]       r_touched, r_timeout;
  logic                       r_scan_done;

  logic [NUM_SENSE*CNT_W-1:0] w_thr;
  logic [NUM_SENSE*CNT_W-1:0] w_cnt_new;
  logic [NUM_SENSE-1:0]       w_touch_next;
  logic                       w_all_latched;

  capsense_thr_regs #(.NUM_SENSE(NUM_SENSE), .CNT_W(CNT_W)) u_thr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (i_thr_we),
    .i_sel   (i_thr_sel),
    .i_data  (i_thr_data),
    .o_thr   (w_thr)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sense_in;
      r_sync2 <= r_sync1;
    end
  end

  // The cycle that latches the last channel is the final CHARGE cycle.
  assign w_all_latched = &(r_latched | r_sync2);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_enable) w_next = S_CHARGE;
      S_CHARGE:    if (w_all_latched || (r_cnt == CNT_MAX)) w_next = S_DISCHARGE;
      S_DISCHARGE: if (r_dis == '0) w_next = S_UPDATE;
      S_UPDATE:    w_next = i_enable ? S_CHARGE : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_charge_out = (r_state == S_CHARGE);
  end

  // CHARGE is only entered from IDLE or UPDATE, both of which hold the
  // counter at zero, so the first CHARGE cycle always sees zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_dis <= '0;
    end else begin
      if (r_state == S_CHARGE) r_cnt <= r_cnt + CNT_W'(1);
      else                     r_cnt <= '0;
      if (r_state == S_CHARGE)                     r_dis <= DW'(DISCH_CYC - 1);
      else if (r_state == S_DISCHARGE && r_dis != '0) r_dis <= r_dis - DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latched <= '0;
      for (int i = 0; i < NUM_SENSE; i++) r_lat[i] <= '0;
    end else if (r_state == S_CHARGE) begin
      for (int i = 0; i < NUM_SENSE; i++) begin
        if (!r_latched[i] && r_sync2[i]) begin
          r_latched[i] <= 1'b1;
          r_lat[i]     <= r_cnt;
        end
      end
    end else if (r_state == S_IDLE || r_state == S_UPDATE) begin
      r_latched <= '0;
    end
  end

  always_comb begin
    w_cnt_new    = '0;
    w_touch_next = r_touched;
    for (int i = 0; i < NUM_SENSE; i++) begin
      logic [CNT_W-1:0] v_cnt, v_thr, v_lo;
      v_cnt = r_latched[i] ? r_lat[i] : CNT_MAX;
      v_thr = w_thr[i*CNT_W +: CNT_W];
      v_lo  = (v_thr > HYST_V) ? (v_thr - HYST_V) : '0;
      w_cnt_new[i*CNT_W +: CNT_W] = v_cnt;
      // Timed-out channels keep their previous touch state.
      if (r_latched[i]) begin
        if (v_cnt > v_thr)     w_touch_next[i] = 1'b1;
        else if (v_cnt < v_lo) w_touch_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count     <= '0;
      r_touched   <= '0;
      r_timeout   <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= (r_state == S_UPDATE);
      if (r_state == S_UPDATE) begin
        r_count   <= w_cnt_new;
        r_timeout <= ~r_latched;
        r_touched <= w_touch_next;
      end
    end
  end

  assign o_count_out = r_count;
  assign o_touched   = r_touched;
  assign o_timeout   = r_timeout;
  assign o_scan_done = r_scan_done;
endmodule

// File: tb/tb_capsense_scan.sv
module tb_capsense_scan;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset, enable, thr_we;
  logic [3:0]  sense_in, thr_sel;
  logic [7:0]  thr_data;
  logic        charge_out, scan_done;
  logic [31:0] count_out;
  logic [3:0]  touched, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  capsense_scan #(.NUM_SENSE(4), .CNT_W(8), .DISCH_CYC(4), .HYST(2)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_sense_in   (sense_in),
    .o_charge_out (charge_out),
    .i_thr_we     (thr_we),
    .i_thr_sel    (thr_sel),
    .i_thr_data   (thr_data),
    .o_count_out  (count_out),
    .o_touched    (touched),
    .o_timeout    (timeout),
    .o_scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one scan. Channel i's raw pin goes high in charge cycle rise_i
  // (cycle 0 is the first charge cycle). wr_at: 1 = threshold write in
  // charge cycle 1, 2 = threshold write in the UPDATE cycle. Returns at
  // the scan_done cycle with the number of charge-high and charge-low cycles.
  task automatic run_scan(input int r0, input int r1, input int r2, input int r3,
                          input int wr_at, input logic [3:0] wsel, input logic [7:0] wdata,
                          input bit drop_en, output int chg, output int lo);
    int rise[4];
    int w;
    int k;
    rise[0] = r0; rise[1] = r1; rise[2] = r2; rise[3] = r3;
    chg = 0; lo = 0; w = 0; k = 0;
    while (!charge_out && w < 20) begin tick(); w++; end
    check("scan_start", {31'd0, charge_out}, 32'd1);
    while (charge_out && k < 400) begin
      for (int i = 0; i < 4; i++) if (k >= rise[i]) sense_in[i] = 1'b1;
      if (wr_at == 1 && k == 1) begin
        thr_we = 1'b1; thr_sel = wsel; thr_data = wdata;
      end else begin
        thr_we = 1'b0;
      end
      if (drop_en && k == 3) enable = 1'b0;
      chg++;
      tick();
      k++;
    end
    sense_in = '0;
    thr_we   = 1'b0;
    while (!scan_done && lo < 20) begin
      if (wr_at == 2 && lo == 4) begin
        thr_we = 1'b1; thr_sel = wsel; thr_data = wdata;
      end else begin
        thr_we = 1'b0;
      end
      lo++;
      tick();
    end
    thr_we = 1'b0;
    check("scan_done_seen", {31'd0, scan_done}, 32'd1);
  endtask

  task automatic check_scan(input string tag, input int chg, input int lo,
                            input int exp_chg, input logic [31:0] exp_cnt,
                            input logic [3:0] exp_to, input logic [3:0] exp_tch);
    check({tag, "_charge_cycles"}, chg, exp_chg);
    check({tag, "_low_cycles"}, lo, 5);
    check({tag, "_count_out"}, count_out, exp_cnt);
    check({tag, "_timeout"}, {28'd0, timeout}, {28'd0, exp_to});
    check({tag, "_touched"}, {28'd0, touched}, {28'd0, exp_tch});
  endtask

  initial begin
    int chg, lo;
    int any_chg, any_done;
    reset = 1'b1; enable = 1'b0; sense_in = '0;
    thr_we = 1'b0; thr_sel = '0; thr_data = '0;

    repeat (10) tick();
    reset = 1'b0;
    tick();
    check("rst_count_out", count_out, 32'd0);
    check("rst_touched", {28'd0, touched}, 32'd0);
    check("rst_timeout", {28'd0, timeout}, 32'd0);
    check("rst_scan_done", {31'd0, scan_done}, 32'd0);
    check("rst_charge", {31'd0, charge_out}, 32'd0);
    any_chg = 0; any_done = 0;
    for (int i = 0; i < 20; i++) begin
      sense_in = 4'(i);
      if (charge_out) any_chg++;
      if (scan_done)  any_done++;
      tick();
    end
    sense_in = '0;
    check("idle_no_charge", any_chg, 0);
    check("idle_no_done", any_done, 0);
    check("idle_count_out", count_out, 32'd0);

    // Out-of-range write must not reach any channel.
    thr_we = 1'b1; thr_sel = 4'd5; thr_data = 8'd0;
    tick();
    thr_we = 1'b0;
    tick();

    enable = 1'b1;
    run_scan(10, 20, 30, 40, 0, 4'd0, 8'd0, 1'b0, chg, lo);
    check_scan("scanA", chg, lo, 43, 32'h2A20160C, 4'b0000, 4'b0000);

    run_scan(5, 5, 33, 5, 1, 4'd2, 8'd30, 1'b0, chg, lo);
    check_scan("scanB", chg, lo, 36, 32'h07230707, 4'b0000, 4'b0100);

    run_scan(5, 5, 27, 5, 0, 4'd0, 8'd0, 1'b0, chg, lo);
    check_scan("scanC", chg, lo, 30, 32'h071D0707, 4'b0000, 4'b0100);

    run_scan(5, 5, 25, 3, 1, 4'd3, 8'd10, 1'b0, chg, lo);
    check_scan("scanD", chg, lo, 28, 32'h051B0707, 4'b0000, 4'b0000);

    run_scan(3, 3, 3, NEVER, 0, 4'd0, 8'd0, 1'b0, chg, lo);
    check_scan("scanE", chg, lo, 256, 32'hFF050505, 4'b1000, 4'b0000);

    run_scan(10, 10, 10, 10, 2, 4'd1, 8'd5, 1'b0, chg, lo);
    check_scan("scanF", chg, lo, 13, 32'h0C0C0C0C, 4'b0000, 4'b1000);

    run_scan(10, 10, 10, 10, 0, 4'd0, 8'd0, 1'b1, chg, lo);
    check_scan("scanG", chg, lo, 13, 32'h0C0C0C0C, 4'b0000, 4'b1010);
    any_chg = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (charge_out) any_chg++;
    end
    check("after_drop_idle", any_chg, 0);

    enable = 1'b1;
    tick();
    check("midrst_charge_on", {31'd0, charge_out}, 32'd1);
    sense_in = 4'hF;
    repeat (3) tick();
    reset = 1'b1; sense_in = '0;
    tick();
    check("midrst_charge", {31'd0, charge_out}, 32'd0);
    check("midrst_count_out", count_out, 32'd0);
    check("midrst_touched", {28'd0, touched}, 32'd0);
    check("midrst_timeout", {28'd0, timeout}, 32'd0);
    check("midrst_scan_done", {31'd0, scan_done}, 32'd0);
    reset = 1'b0;
    tick();
    check("rel_charge_start", {31'd0, charge_out}, 32'd1);
    run_scan(0, 18, 2, 3, 0, 4'd0, 8'd0, 1'b1, chg, lo);
    check_scan("scanH", chg, lo, 21, 32'h05041402, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
